// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-segment scan controller: state encoding and symbol code width.
package seg_scan_pkg;

    localparam int CODE_W = 4;
    localparam logic [CODE_W-1:0] CODE_BLANK = 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter that saturates at zero; o_tc is high while the count sits at zero.
module seg_scan_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner feeding one shared 7-segment decoder, with a double-buffered frame.
// Optional per-digit blinking is compiled in when SEG_SCAN_BLINK_EN is defined.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYCLES  = 500,
    parameter int EN_ACTIVE_LOW = 1
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES  = 64
`endif
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_enable,
    input  logic                         i_load,
    input  logic [CODE_W*NUM_DIGITS-1:0] i_codes,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]        i_blink_mask,
`endif
    output logic [CODE_W-1:0]            o_code,
    output logic [NUM_DIGITS-1:0]        o_digit_en,
    output logic                         o_frame_done,
    output logic                         o_pending
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{EN_ACTIVE_LOW != 0}};

    scan_state_t                  r_state;
    logic [IDX_W-1:0]             r_idx;
    logic [CODE_W*NUM_DIGITS-1:0] r_active;
    logic [CODE_W*NUM_DIGITS-1:0] r_pendFrame;
    logic                         r_pending;
    logic [CODE_W-1:0]            r_code;
    logic [NUM_DIGITS-1:0]        r_digitEn;
    logic                         r_frameDone;

    logic                         w_slotTc;
    logic                         w_slotLoad;
    logic [CNT_W-1:0]             w_slotLoadVal;
    logic                         w_lastDigit;
    logic                         w_boundary;
    logic                         w_commit;
    logic [IDX_W-1:0]             w_nextIdx;
    logic [CODE_W*NUM_DIGITS-1:0] w_nextActive;
    logic [NUM_DIGITS-1:0]        w_oneHot;
    logic                         w_blankDigit;

    assign w_lastDigit = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_boundary  = i_enable && (r_state == DRIVE) && w_slotTc && w_lastDigit;
    // Any point where no frame is on display is a safe moment to swap frames.
    assign w_commit    = !i_enable || (r_state == IDLE) || w_boundary;
    assign w_nextIdx   = w_lastDigit ? '0 : r_idx + 1'b1;
    assign w_oneHot    = NUM_DIGITS'(1) << r_idx;

    always_comb begin
        w_nextActive = r_active;
        if (w_commit) begin
            if (i_load) begin
                w_nextActive = i_codes;
            end else if (r_pending) begin
                w_nextActive = r_pendFrame;
            end
        end
    end

    always_comb begin
        w_slotLoad    = 1'b0;
        w_slotLoadVal = '0;
        if (!i_enable) begin
            w_slotLoad = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_slotLoad    = 1'b1;
                    w_slotLoadVal = CNT_W'(BLANK_CYCLES - 1);
                end
                BLANK: begin
                    w_slotLoad    = w_slotTc;
                    w_slotLoadVal = CNT_W'(SCAN_DIV - 1);
                end
                DRIVE: begin
                    w_slotLoad    = w_slotTc;
                    w_slotLoadVal = CNT_W'(BLANK_CYCLES - 1);
                end
                default: begin
                    w_slotLoad = 1'b1;
                end
            endcase
        end
    end

    seg_scan_timer #(.W(CNT_W)) u_slotTimer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_slotLoad),
        .i_load_val (w_slotLoadVal),
        .i_dec      (1'b1),
        .o_tc       (w_slotTc)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    logic r_blinkPhase;
    logic w_blinkTc;
    logic w_blinkLoad;

    // The frame counter is parked at its reload value whenever the scanner is idle.
    assign w_blinkLoad  = !i_enable || (r_state == IDLE) || (w_boundary && w_blinkTc);
    assign w_blankDigit = r_blinkPhase && i_blink_mask[r_idx];

    seg_scan_timer #(.W(BLINK_W)) u_blinkTimer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_blinkLoad),
        .i_load_val (BLINK_W'(BLINK_FRAMES - 1)),
        .i_dec      (w_boundary),
        .o_tc       (w_blinkTc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_blinkPhase <= 1'b0;
        end else if (!i_enable || (r_state == IDLE)) begin
            r_blinkPhase <= 1'b0;
        end else if (w_boundary && w_blinkTc) begin
            r_blinkPhase <= ~r_blinkPhase;
        end
    end
`else
    assign w_blankDigit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_active    <= '0;
            r_pendFrame <= '0;
            r_pending   <= 1'b0;
            r_code      <= CODE_BLANK;
            r_digitEn   <= EN_OFF;
            r_frameDone <= 1'b0;
        end else begin
            r_active    <= w_nextActive;
            r_pending   <= !w_commit && (i_load || r_pending);
            r_frameDone <= 1'b0;
            if (i_load && !w_commit) begin
                r_pendFrame <= i_codes;
            end
            if (!i_enable) begin
                r_state   <= IDLE;
                r_idx     <= '0;
                r_code    <= CODE_BLANK;
                r_digitEn <= EN_OFF;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state   <= BLANK;
                        r_idx     <= '0;
                        r_code    <= w_nextActive[0 +: CODE_W];
                        r_digitEn <= EN_OFF;
                    end
                    BLANK: begin
                        if (w_slotTc) begin
                            r_state   <= DRIVE;
                            r_digitEn <= w_oneHot ^ EN_OFF;
                            if (w_blankDigit) begin
                                r_code <= CODE_BLANK;
                            end
                        end
                    end
                    DRIVE: begin
                        if (w_slotTc) begin
                            r_state     <= BLANK;
                            r_idx       <= w_nextIdx;
                            r_digitEn   <= EN_OFF;
                            r_code      <= w_nextActive[w_nextIdx*CODE_W +: CODE_W];
                            r_frameDone <= w_lastDigit;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_code       = r_code;
    assign o_digit_en   = r_digitEn;
    assign o_frame_done = r_frameDone;
    assign o_pending    = r_pending;

endmodule
